stream_run_source: RTL and testbench
====================================

Name: stream_run_source

Overview:
- Successor to the single-cycle network source. Converts an opcode-tagged input stream into network input cycles and network resets.
- Adds a registered output stage and a multi-cycle RUN opcode that issues N idle (zero-charge) network cycles from one word.
- Adds a stretched, sequenced network clear.
- Sits between the host-facing stream decoder and the network core.

Parameters:
- NUM_INP, 4, number of network input channels.
- CHARGE_WIDTH, 8, signed charge width per channel.
- RUN_WIDTH, 16, width of the RUN cycle count.
- CLR_CYCLES, 2, cycles net_arstn is held low per CLR; must be ≥1.
- OPC_WIDTH, 2, opcode field width (derived constant, not overridable).
- PAY_WIDTH, max(NUM_INP*CHARGE_WIDTH, RUN_WIDTH), payload width (derived constant).

Ports:
- clk  in  1  clock; all logic on posedge
- arstn  in  1  async active-low reset
- src_valid  in  1  source word valid
- src_ready  out  1  block accepts source word
- src  in  OPC_WIDTH+PAY_WIDTH  {opcode[MSBs], payload}
- net_ready  in  1  network consumes current input cycle
- net_valid  out  1  net_inp holds a cycle to run
- net_arstn  out  1  network reset, active low
- net_inp  out  NUM_INP x CHARGE_WIDTH signed  channel charges; channel i = payload bits [PAY_WIDTH-1-i*CHARGE_WIDTH -: CHARGE_WIDTH]

Behaviour:
- Opcodes: NOM=0 (one cycle with payload charges); RUN=1 (N = payload[RUN_WIDTH-1:0] zero-charge cycles); CLR=2; 3 reserved.
- Reset (arstn low): state IDLE, net_valid=0, net_inp all 0, net_arstn=0, counters 0.
  - net_arstn rises on the first posedge after arstn deasserts.
- Output register:
  - load_ok = !net_valid || net_ready.
  - net_valid/net_inp change only on load_ok.
  - A loaded cycle is stable until net_ready is seen with net_valid.
- States: IDLE, RUN, CLR_WAIT, CLR.
- src_ready = (state==IDLE) && load_ok. It depends on state and net_ready only, never on src. A word transfers on src_valid && src_ready.
- IDLE:
  - NOM: load charges, net_valid=1 next cycle. Latency 1 cycle. Throughput 1 word/cycle when net_ready is held high.
  - RUN with N=0: word consumed, no cycle issued, stay IDLE.
  - RUN with N≥1: load zeros, net_valid=1, cnt=N-1. Go RUN if cnt>0, else stay IDLE.
  - CLR: go CLR_WAIT. No output load that cycle; net_valid drops if net_ready consumed the pending cycle.
  - Reserved (3): word consumed, no effect.
  - If the transfer cycle has no word, net_valid is cleared when net_ready consumes the pending cycle.
- RUN: on each load_ok, load zeros with net_valid=1 and decrement cnt. The load with cnt==1 returns to IDLE. Exactly N cycles are presented for RUN N. Max N = 2^RUN_WIDTH-1; no wrap.
- CLR_WAIT:
  - Hold until net_valid==0, or net_valid && net_ready (pending cycle drains).
  - Then net_valid=0, net_arstn=0, ccnt=CLR_CYCLES-1, go CLR.
- CLR:
  - net_arstn stays low with net_valid=0.
  - Decrement ccnt each cycle. At ccnt==0, net_arstn=1 and go IDLE; src_ready may rise in the same cycle.
  - net_arstn is registered and glitch-free, low for exactly CLR_CYCLES cycles.
- net_ready low with net_valid high: all state frozen, src_ready=0.
- Reset mid-RUN/CLR: state aborts immediately to reset values. Any remaining count is discarded.

Optional Feature:
- Macro: STREAM_RUN_SOURCE_ERR_EN.
- Enabled:
  - Extra output port err (1 bit), reset 0.
  - err sets sticky on acceptance of opcode 3, or RUN with N=0 when the block is in IDLE.
  - err clears only on arstn or on acceptance of CLR (cleared when entering CLR_WAIT).
- Disabled: no err port. Opcode 3 and RUN 0 are silently consumed.

Test Plan:
- Reset release, src_valid=0 → net_arstn 0 during reset, 1 at first posedge after; net_valid=0; net_inp=0; src_ready=1.
- NOM charges {5,-3,0,127}, net_ready=1 → next cycle net_valid=1, net_inp={5,-3,0,127}; next NOM back-to-back accepted each cycle.
- RUN N=3 with net_ready toggling 1,0,1,1,1 → exactly 3 valid zero-charge handshakes; src_ready=0 until the last load, then 1.
- NOM then CLR with net_ready=0 for 2 cycles → NOM cycle held stable; net_arstn stays 1 until it drains, then low for exactly CLR_CYCLES=2 cycles with net_valid=0; src_ready=1 after.
- RUN N=0 and opcode 3 → no net_valid; with STREAM_RUN_SOURCE_ERR_EN err=1 sticky until next CLR accepted.
- arstn asserted mid-RUN (cnt=5) → net_valid=0, net_arstn=0 immediately; after release IDLE, no residual cycles.

Source files
------------

// File: rtl/stream_run_source.sv
// stream_run_source: opcode stream to registered network cycles (NOM/RUN) and stretched network clears.
// Define STREAM_RUN_SOURCE_ERR_EN to add a sticky err output for reserved opcodes and RUN 0.
module stream_run_source #(
   parameter int NUM_INP = 4,
   parameter int CHARGE_WIDTH = 8,
   parameter int RUN_WIDTH = 16,
   parameter int CLR_CYCLES = 2,
   localparam int OPC_WIDTH = 2,
   localparam int PAY_WIDTH = (NUM_INP * CHARGE_WIDTH > RUN_WIDTH) ? NUM_INP * CHARGE_WIDTH : RUN_WIDTH
) (
   input  logic                                          clk,
   input  logic                                          arstn,
   input  logic                                          src_valid,
   output logic                                          src_ready,
   input  logic [OPC_WIDTH+PAY_WIDTH-1:0]                src,
   input  logic                                          net_ready,
   output logic                                          net_valid,
   output logic                                          net_arstn,
   output logic signed [NUM_INP-1:0][CHARGE_WIDTH-1:0]   net_inp
`ifdef STREAM_RUN_SOURCE_ERR_EN
   ,
   output logic                                          err
`endif
);
   localparam int CCW = CLR_CYCLES > 1 ? $clog2(CLR_CYCLES) : 1;
   localparam logic [OPC_WIDTH-1:0] OP_NOM = 2'd0, OP_RUN = 2'd1, OP_CLR = 2'd2, OP_RES = 2'd3;
   typedef enum logic [1:0] {IDLE, RUN, CLR_WAIT, CLR} state_t;
   state_t state_q, state_d;
   logic valid_q, valid_d, nrst_q, nrst_d;
   logic [NUM_INP-1:0][CHARGE_WIDTH-1:0] inp_q, inp_d, chg;
   logic [RUN_WIDTH-1:0] cnt_q, cnt_d, run_n;
   logic [CCW-1:0] ccnt_q, ccnt_d;
   logic [OPC_WIDTH-1:0] opc;
   logic [PAY_WIDTH-1:0] pay;
   logic load_ok, xfer;
   assign {opc, pay} = src;
   assign run_n = pay[RUN_WIDTH-1:0];
   assign load_ok = !valid_q || net_ready;
   assign src_ready = (state_q == IDLE) && load_ok;
   assign xfer = src_valid && src_ready;
   assign net_valid = valid_q;
   assign net_arstn = nrst_q;
   assign net_inp = inp_q;
   // channel 0 sits in the payload MSBs
   always_comb
      for (int i = 0; i < NUM_INP; i++)
         chg[i] = pay[PAY_WIDTH-1-i*CHARGE_WIDTH -: CHARGE_WIDTH];
   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      inp_d = inp_q;
      cnt_d = cnt_q;
      ccnt_d = ccnt_q;
      nrst_d = 1'b1;
      case (state_q)
         IDLE: if (load_ok) begin
            valid_d = 1'b0;
            if (xfer && opc == OP_NOM) begin
               valid_d = 1'b1;
               inp_d = chg;
            end else if (xfer && opc == OP_RUN && run_n != '0) begin
               valid_d = 1'b1;
               inp_d = '0;
               cnt_d = run_n - 1'b1;
               state_d = run_n != 1 ? RUN : IDLE;
            end else if (xfer && opc == OP_CLR) begin
               state_d = CLR_WAIT;
            end
         end
         RUN: if (load_ok) begin
            valid_d = 1'b1;
            inp_d = '0;
            cnt_d = cnt_q - 1'b1;
            state_d = cnt_q == 1 ? IDLE : RUN;
         end
         CLR_WAIT: if (load_ok) begin
            valid_d = 1'b0;
            nrst_d = 1'b0;
            ccnt_d = CCW'(CLR_CYCLES - 1);
            state_d = CLR;
         end
         CLR: begin
            valid_d = 1'b0;
            nrst_d = ccnt_q == '0;
            ccnt_d = ccnt_q == '0 ? ccnt_q : ccnt_q - 1'b1;
            state_d = ccnt_q == '0 ? IDLE : CLR;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge arstn)
      if (!arstn) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         inp_q <= '0;
         cnt_q <= '0;
         ccnt_q <= '0;
         nrst_q <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         inp_q <= inp_d;
         cnt_q <= cnt_d;
         ccnt_q <= ccnt_d;
         nrst_q <= nrst_d;
      end
`ifdef STREAM_RUN_SOURCE_ERR_EN
   logic err_q, err_d;
   always_comb begin
      err_d = err_q;
      if (xfer && (opc == OP_RES || (opc == OP_RUN && run_n == '0)))
         err_d = 1'b1;
      else if (xfer && opc == OP_CLR)
         err_d = 1'b0;
   end
   always_ff @(posedge clk or negedge arstn)
      if (!arstn)
         err_q <= 1'b0;
      else
         err_q <= err_d;
   assign err = err_q;
`endif
endmodule

// File: tb/tb_stream_run_source.sv
// tb_stream_run_source: random + directed stimulus against a transaction-queue model of the network side.
module tb_stream_run_source;
   localparam int CLR_CYCLES = 2;
   typedef struct {logic c; logic [31:0] d;} item_t;
   logic clk = 1'b0, arstn = 1'b0, src_valid = 1'b0, net_ready = 1'b0;
   logic [33:0] src = '0;
   logic src_ready, net_valid, net_arstn;
   logic [3:0][7:0] net_inp;
   item_t q[$];
   int n_vec = 0, n_err = 0, low = 0, wt = 0;
   logic clr_active = 1'b0, err_m = 1'b0;
`ifdef STREAM_RUN_SOURCE_ERR_EN
   logic err;
`endif
   stream_run_source #(.CLR_CYCLES(CLR_CYCLES)) dut (
      .clk(clk), .arstn(arstn), .src_valid(src_valid), .src_ready(src_ready), .src(src),
      .net_ready(net_ready), .net_valid(net_valid), .net_arstn(net_arstn), .net_inp(net_inp)
`ifdef STREAM_RUN_SOURCE_ERR_EN
      , .err(err)
`endif
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   // payload byte 0 (MSBs) is channel 0, which is net_inp[0] (LSBs of the packed port)
   function automatic logic [31:0] to_net(input logic [31:0] p);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[i*8 +: 8] = p[31-8*i -: 8];
      return r;
   endfunction
   function automatic logic [33:0] word(input logic [1:0] op, input logic [31:0] p);
      return {op, p};
   endfunction
   task automatic accept(input logic [33:0] w);
      case (w[33:32])
         2'd0: q.push_back('{1'b0, to_net(w[31:0])});
         2'd1: begin
            if (w[15:0] == 0) err_m = 1'b1;
            for (int k = 0; k < int'(w[15:0]); k++) q.push_back('{1'b0, 32'd0});
         end
         2'd2: begin q.push_back('{1'b1, 32'd0}); err_m = 1'b0; end
         default: err_m = 1'b1;
      endcase
   endtask
   task automatic step(input logic sv, input logic [33:0] w, input logic nr);
      logic exp_v;
      @(negedge clk);
      src_valid = sv;
      src = w;
      net_ready = nr;
      #1;
      if (!net_arstn) begin
         if (!clr_active) begin
            check("clr_front", q.size() > 0 && q[0].c, 1);
            if (q.size() > 0) void'(q.pop_front());
            clr_active = 1'b1;
            low = 0;
         end
         low++;
      end else if (clr_active) begin
         check("clr_len", low, CLR_CYCLES);
         clr_active = 1'b0;
      end
      if (net_arstn && q.size() > 0 && q[0].c) begin
         wt++;
         check("clr_lat", wt <= 1, 1);
      end else wt = 0;
      exp_v = q.size() > 0 && !q[0].c;
      check("net_valid", net_valid, exp_v);
      if (exp_v) check("net_inp", net_inp, q[0].d);
      check("src_ready", src_ready, !clr_active && (q.size() == 0 || (q.size() == 1 && !q[0].c && nr)));
`ifdef STREAM_RUN_SOURCE_ERR_EN
      check("err", err, err_m);
`endif
      if (net_valid && nr && q.size() > 0 && !q[0].c) void'(q.pop_front());
      if (sv && src_ready) accept(w);
   endtask
   function automatic logic [33:0] rand_word();
      int r = $urandom_range(0, 99);
      logic [31:0] p = $urandom;
      if (r < 50) return word(2'd0, p);
      if (r < 75) return word(2'd1, {p[31:16], 16'($urandom_range(0, 6))});
      if (r < 88) return word(2'd2, p);
      return word(2'd3, p);
   endfunction
   initial begin
      repeat (2) @(negedge clk);
      check("rst_arstn", net_arstn, 0);
      check("rst_valid", net_valid, 0);
      check("rst_inp", net_inp, 0);
      arstn = 1'b1;
      step(1'b0, '0, 1'b1);
      check("rst_rel", net_arstn, 1);
      step(1'b1, word(2'd0, {8'd5, 8'hFD, 8'd0, 8'd127}), 1'b1);
      step(1'b1, word(2'd0, 32'h8001_7F80), 1'b1);
      check("chan1", 8'(net_inp[1]), 8'hFD);
      step(1'b1, word(2'd0, 32'h1234_5678), 1'b1);
      step(1'b1, word(2'd1, 32'hABCD_0003), 1'b1);
      step(1'b0, '0, 1'b0);
      repeat (3) step(1'b0, '0, 1'b1);
      step(1'b1, word(2'd0, 32'hDEAD_BEEF), 1'b1);
      repeat (2) step(1'b1, word(2'd2, 0), 1'b0);
      step(1'b1, word(2'd2, 0), 1'b1);
      repeat (4) step(1'b0, '0, 1'b1);
      step(1'b1, word(2'd1, 32'hFFFF_0000), 1'b1);
      step(1'b1, word(2'd3, 32'h0), 1'b1);
      repeat (2) step(1'b0, '0, 1'b1);
      step(1'b1, word(2'd2, 0), 1'b1);
      repeat (4) step(1'b0, '0, 1'b1);
      step(1'b1, word(2'd1, 32'h0000_0006), 1'b1);
      step(1'b0, '0, 1'b1);
      @(negedge clk);
      #2 arstn = 1'b0;
      #1;
      check("amid_valid", net_valid, 0);
      check("amid_arstn", net_arstn, 0);
      q.delete();
      clr_active = 1'b0;
      wt = 0;
      err_m = 1'b0;
      @(negedge clk);
      arstn = 1'b1;
      repeat (8) step(1'b0, '0, 1'b1);
      repeat (3000) step($urandom_range(0, 9) < 7, rand_word(), $urandom_range(0, 9) < 7);
      repeat (40) step(1'b0, '0, 1'b1);
      check("drain", q.size(), 0);
      check("drain_clr", clr_active, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
